// File: rtl/poly1305_blockfeed.sv
// Poly1305 block feeder: packs little-endian message bytes into 16-byte blocks with the high "1" bit,
// issues them to the block processor and holds the running accumulator until the finalizer takes it.
module poly1305_blockfeed #(
   parameter bit CLAMP_R = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] key_r,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic [127:0] pb_r,
   output logic [128:0] pb_m,
   output logic [129:0] pb_a,
   output logic         pb_start,
   input  logic         pb_done,
   input  logic [129:0] pb_a_res,
   output logic         acc_valid,
   input  logic         acc_ready,
   output logic [129:0] acc_out
);
   localparam logic [127:0] ClampMask = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

   typedef enum logic [1:0] {StFill, StIssue, StWait, StOut} state_e;

   state_e       state_q;
   logic [3:0]   cnt_q;
   logic [127:0] buf_q;
   logic         last_q;
   logic         first_q;

   logic         accept;
   logic         close;
   logic [4:0]   nbytes;
   logic [127:0] buf_d;
   logic [128:0] blk_m;
   logic [127:0] r_in;

   assign in_ready = (state_q == StFill) && !reset;
   assign accept   = in_valid && in_ready;
   assign close    = (cnt_q == 4'd15) || in_last;
   assign nbytes   = {1'b0, cnt_q} + 5'd1;
   assign acc_out  = pb_a;
   assign r_in     = CLAMP_R ? (key_r & ClampMask) : key_r;

   // Block as it would look if the byte on in_data closes it: unused bytes zeroed, then the
   // Poly1305 "1" appended directly above the last message byte.
   always_comb begin
      buf_d = buf_q;
      buf_d[{cnt_q, 3'b000} +: 8] = in_data;
      blk_m = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (5'(i) < nbytes) blk_m[8*i +: 8] = buf_d[8*i +: 8];
      end
      if (nbytes == 5'd16) begin
         blk_m[128] = 1'b1;
      end else begin
         blk_m[{1'b0, nbytes[3:0], 3'b000}] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFill;
         cnt_q     <= '0;
         buf_q     <= '0;
         last_q    <= 1'b0;
         first_q   <= 1'b1;
         pb_r      <= '0;
         pb_m      <= '0;
         pb_a      <= '0;
         pb_start  <= 1'b0;
         acc_valid <= 1'b0;
      end else begin
         pb_start <= 1'b0;
         unique case (state_q)
            StFill: begin
               if (accept) begin
                  buf_q <= buf_d;
                  cnt_q <= cnt_q + 4'd1;
                  if ((cnt_q == 4'd0) && first_q) begin
                     pb_r    <= r_in;
                     pb_a    <= '0;
                     first_q <= 1'b0;
                  end
                  if (close) begin
                     pb_m     <= blk_m;
                     last_q   <= in_last;
                     cnt_q    <= '0;
                     pb_start <= 1'b1;
                     state_q  <= StIssue;
                  end
               end
            end
            StIssue, StWait: begin
               if (pb_done) begin
                  pb_a  <= pb_a_res;
                  buf_q <= '0;
                  if (last_q) begin
                     acc_valid <= 1'b1;
                     state_q   <= StOut;
                  end else begin
                     state_q <= StFill;
                  end
               end else begin
                  state_q <= StWait;
               end
            end
            StOut: begin
               if (acc_ready) begin
                  acc_valid <= 1'b0;
                  pb_a      <= '0;
                  first_q   <= 1'b1;
                  state_q   <= StFill;
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

endmodule
